// File: rtl/div_unit_if.sv
// Bundles the start/busy/done handshake, operands and flagged result of div_unit.
// The master drives the request side and the slave returns the result side.
interface div_unit_if #(
    parameter int n = 32
);
    logic         start;
    logic [n-1:0] SrcA;
    logic [n-1:0] SrcB;
    logic [1:0]   DivControl;
    logic         busy;
    logic         done;
    logic [n-1:0] Result;
    logic         Zero;
    logic         Sign;

    modport master (
        output start, SrcA, SrcB, DivControl,
        input  busy, done, Result, Zero, Sign
    );

    modport slave (
        input  start, SrcA, SrcB, DivControl,
        output busy, done, Result, Zero, Sign
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, restoring, one quotient bit per clock.
// Operations run on operand magnitudes, and the signs are fixed in a final FIX cycle.
// Optional macro DIV_EARLY_OUT_EN: when it is defined, divide-by-zero and signed
// overflow finish straight from the accepting edge with the same result values.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | n restoring iterations, busy high
// FIX   | sign correction and result select, busy high
// DONE  | done pulse; start here chains the next operation
module div_unit #(
    parameter int n = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [n-1:0]  r_rem;
    logic [n-1:0]  r_quo;
    logic [n-1:0]  r_div;
    logic [CW-1:0] r_cnt;
    logic          r_neg_q;
    logic          r_neg_r;
    logic          r_sel_rem;
    logic [n-1:0]  r_result;
    logic          r_zero;
    logic          r_sign;

    logic          w_busy;
    logic          w_done;
    logic          w_accept;
    logic          w_early;
    logic [n-1:0]  w_special_res;

    // DivControl[0]=0 selects the signed variants (DIV, REM)
    logic          w_signed;
    logic          w_sign_a;
    logic          w_sign_b;
    logic          w_b_zero;
    logic [n-1:0]  w_abs_a;
    logic [n-1:0]  w_abs_b;

    assign w_signed = ~bus.DivControl[0];
    assign w_sign_a = w_signed & bus.SrcA[n-1];
    assign w_sign_b = w_signed & bus.SrcB[n-1];
    assign w_b_zero = (bus.SrcB == '0);
    assign w_abs_a  = w_sign_a ? -bus.SrcA : bus.SrcA;
    assign w_abs_b  = w_sign_b ? -bus.SrcB : bus.SrcB;

    assign w_accept = bus.start & ((r_state == IDLE) | (r_state == DONE));

`ifdef DIV_EARLY_OUT_EN
    logic w_ovf;
    logic w_special;
    assign w_ovf     = w_signed & (bus.SrcA == {1'b1, {(n-1){1'b0}}}) & (bus.SrcB == '1);
    assign w_special = w_b_zero | w_ovf;
    assign w_early   = w_accept & w_special;
    always_comb begin
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = bus.DivControl[1] ? bus.SrcA : '1;
        end else begin
            w_special_res = bus.DivControl[1] ? '0 : {1'b1, {(n-1){1'b0}}};
        end
    end
`else
    assign w_early       = 1'b0;
    assign w_special_res = '0;
`endif

    // One restoring step: shift in the next dividend bit and try to subtract
    logic [n:0]   w_shift;
    logic [n:0]   w_diff;
    logic [n-1:0] w_rem_next;
    logic [n-1:0] w_quo_next;

    assign w_shift    = {r_rem, r_quo[n-1]};
    assign w_diff     = w_shift - {1'b0, r_div};
    assign w_rem_next = w_diff[n] ? w_shift[n-1:0] : w_diff[n-1:0];
    assign w_quo_next = {r_quo[n-2:0], ~w_diff[n]};

    logic [n-1:0] w_q_fix;
    logic [n-1:0] w_r_fix;
    logic [n-1:0] w_fix_res;

    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
    assign w_fix_res = r_sel_rem ? w_r_fix : w_q_fix;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_next = w_early ? DONE : CALC;
                end
            end
            CALC: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(n - 1)) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_busy       = 1'b1;
                w_state_next = DONE;
            end
            DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_state_next = w_early ? DONE : CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand latch, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_sign    <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_div     <= w_abs_b;
            r_cnt     <= '0;
            // x/0 must stay all ones, so a zero divisor never negates the quotient
            r_neg_q   <= (w_sign_a ^ w_sign_b) & ~w_b_zero;
            r_neg_r   <= w_sign_a;
            r_sel_rem <= bus.DivControl[1];
            if (w_early) begin
                r_result <= w_special_res;
                r_zero   <= (w_special_res == '0);
                r_sign   <= w_special_res[n-1];
            end
        end else if (r_state == CALC) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
        end else if (r_state == FIX) begin
            r_result <= w_fix_res;
            r_zero   <= (w_fix_res == '0);
            r_sign   <= w_fix_res[n-1];
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.Result = r_result;
    assign bus.Zero   = r_zero;
    assign bus.Sign   = r_sign;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (n=32); latency expectations follow DIV_EARLY_OUT_EN.
module tb_div_unit;
    localparam int N        = 32;
    localparam int NORM_LAT = N + 2;
`ifdef DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = N + 2;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_unit_if #(.n(N)) u_if ();

    div_unit #(.n(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one op with a single-cycle start, then checks latency, busy time, result and flags
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        int busy_cyc;
        bit seen;
        u_if.DivControl = op;
        u_if.SrcA       = a;
        u_if.SrcB       = b;
        u_if.start      = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        seen     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
            if (u_if.busy) busy_cyc++;
            @(posedge clk);
            lat++;
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cyc), 32'(exp_lat - 1));
        check({tag, " busy_at_done"}, 32'(u_if.busy), 32'd0);
        check({tag, " result"}, u_if.Result, exp);
        check({tag, " zero"}, 32'(u_if.Zero), 32'(exp == 32'd0));
        check({tag, " sign"}, 32'(u_if.Sign), 32'(exp[31]));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(u_if.done), 32'd0);
    endtask

    initial begin
        int lat;
        int gap;
        int dones;
        bit seen;

        rst             = 1'b1;
        u_if.start      = 1'b0;
        u_if.SrcA       = '0;
        u_if.SrcB       = '0;
        u_if.DivControl = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(u_if.busy), 32'd0);
        check("reset done", 32'(u_if.done), 32'd0);
        check("reset result", u_if.Result, 32'd0);
        check("reset zero", 32'(u_if.Zero), 32'd1);
        check("reset sign", 32'(u_if.Sign), 32'd0);

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, NORM_LAT);
        run_op("div_m100_7", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NORM_LAT);
        run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NORM_LAT);
        run_op("div_100_m7", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, NORM_LAT);
        run_op("rem_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, NORM_LAT);
        run_op("div_m100_m7", 2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, NORM_LAT);
        run_op("rem_m100_m7", 2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, NORM_LAT);
        run_op("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, SPEC_LAT);
        run_op("div_m100_0", 2'b00, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
        run_op("rem_m100_0", 2'b10, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, SPEC_LAT);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);
        run_op("divu_min_ones", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORM_LAT);
        run_op("remu_min_ones", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM_LAT);
        run_op("divu_ones_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORM_LAT);

        // A second start at cycle 10 of a busy op must not disturb it
        u_if.DivControl = 2'b01;
        u_if.SrcA       = 32'd1000;
        u_if.SrcB       = 32'd10;
        u_if.start      = 1'b1;
        @(posedge clk);
        #1 u_if.start = 1'b0;
        lat = 1;
        repeat (9) begin
            @(posedge clk);
            lat++;
        end
        #1;
        u_if.DivControl = 2'b11;
        u_if.SrcA       = 32'd7;
        u_if.SrcB       = 32'd7;
        u_if.start      = 1'b1;
        @(posedge clk);
        lat++;
        #1 u_if.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        check("ignore_start done_seen", 32'(seen), 32'd1);
        check("ignore_start latency", 32'(lat), 32'(NORM_LAT));
        check("ignore_start result", u_if.Result, 32'd100);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_if.done) dones++;
        end
        check("ignore_start extra_done", 32'(dones), 32'd0);

        // start held high: back-to-back ops, then reset in the middle of one
        u_if.DivControl = 2'b01;
        u_if.SrcA       = 32'd100;
        u_if.SrcB       = 32'd7;
        u_if.start      = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b first_done", 32'(seen), 32'd1);
        gap  = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            gap++;
            if (u_if.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b second_done", 32'(seen), 32'd1);
        check("b2b done_interval", 32'(gap), 32'(NORM_LAT));
        check("b2b result", u_if.Result, 32'd14);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("b2b busy_before_rst", 32'(u_if.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid busy", 32'(u_if.busy), 32'd0);
        check("rst_mid done", 32'(u_if.done), 32'd0);
        check("rst_mid result", u_if.Result, 32'd0);
        check("rst_mid zero", 32'(u_if.Zero), 32'd1);
        check("rst_mid sign", 32'(u_if.Sign), 32'd0);
        rst        = 1'b0;
        u_if.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (u_if.done) dones++;
        end
        check("rst_mid no_done", 32'(dones), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit. Executes DIV, DIVU, REM and REMU for the execute stage, alongside the combinational ALU.
- Takes the same SrcA/SrcB operands as the ALU and returns a result plus Zero/Sign flags.
- Uses a start/busy/done handshake, so the pipeline stalls while busy is high.
- Restoring algorithm, one quotient bit per clock.

Parameters:
n, 32, operand and result width in bits (n >= 2)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE or DONE
SrcA  input  n  dividend; latched on the accepting edge
SrcB  input  n  divisor; latched on the accepting edge
DivControl  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]); latched with the operands
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; Result is valid from this cycle on
Result  output  n  quotient or remainder; held until the next accepted start or reset
Zero  output  1  high when Result == 0 (registered with Result)
Sign  output  1  equals Result[n-1] (registered with Result)

Behaviour:
- Interface requirement: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; busy=0, done=0, Result=0, Zero=1, Sign=0. Iteration counter and internal registers are cleared.
- States:
  - IDLE: waits for start.
  - CALC: iterates; busy=1.
  - FIX: sign correction; busy=1.
  - DONE: done=1 for exactly one cycle.
- IDLE to CALC: on an edge E0 with start=1.
  - Latch |SrcA| and |SrcB|; magnitudes apply for signed ops only.
  - Latch the quotient-negate flag (sign A xor sign B) and the remainder-negate flag (sign A).
  - Clear the partial remainder; counter = 0.
- CALC, edges E1..En (one per edge):
  - Shift {rem, quo} left by 1.
  - If the trial remainder minus divisor is non-negative: subtract and set the quotient LSB.
  - Counter increments; at En the state moves to FIX.
- FIX, edge En+1:
  - Apply negation to the quotient and/or remainder.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU).
  - Register Result, Zero and Sign; state moves to DONE.
- DONE: done=1 and busy=0 in the cycle after En+1.
  - Next edge: to CALC if start=1 (back-to-back operation), otherwise to IDLE.
  - done is low in every other state.
- Latency: start edge to done-high is n+2 edges (34 for n=32). Throughput is one op per n+2 cycles.
- start while busy is ignored; the in-flight operation and its latched operands are unaffected.
- Divide by zero (SrcB=0):
  - DIV/DIVU: Result = all ones.
  - REM/REMU: Result = SrcA.
  - Produced by the natural iteration; no trap.
- Signed overflow (DIV, SrcA=2^(n-1) as signed minimum, SrcB=all ones): Result = 2^(n-1). REM in the same case gives 0.
- Signed results:
  - Quotient truncates toward zero.
  - Remainder takes the dividend's sign (RISC-V semantics).
- Reset mid-operation aborts on that edge: no done pulse, outputs return to reset values.
- rst has priority over start on the same edge.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined:
  - Divide-by-zero and signed-overflow cases are detected at the accepting edge E0.
  - FSM goes directly to DONE with the special-case Result registered at E0.
  - done is high in the cycle after E0, a latency of 1 edge. CALC and FIX are skipped.
  - Normal operands are unchanged: n+2 edges.
- Undefined: every operation takes n+2 edges, special cases included. Result values are identical in both builds.

Test Plan:
- Reset then DIVU 100/7 -> done after 34 edges, Result=14, Zero=0, Sign=0; busy high for exactly 33 cycles.
- DIV 0xFFFFFF9C (-100) / 7, then REM with the same operands -> Result 0xFFFFFFF2 (-14), then 0xFFFFFFFE (-2), Sign=1.
- DIVU 5/0 -> Result 0xFFFFFFFF; REMU 5/0 -> Result 5.
  - With DIV_EARLY_OUT_EN, done one cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF -> Result 0x80000000; REM with the same operands -> Result 0, Zero=1.
- start pulsed again at cycle 10 of a busy op with different operands -> ignored; the first result is delivered and only one done pulse occurs.
- start held high continuously -> back-to-back ops, done pulses every 34 cycles.
  - rst asserted at cycle 20 of an op -> next cycle busy=0, done=0, Result=0, Zero=1, and no done pulse follows.
